// File: rtl/procyon_dcache_arb.sv
// D0 request port arbiter: line fills vs. LSU ops.
// One-cycle registered issue with LSU anti-starvation.
module procyon_dcache_arb #(
  parameter int OPTN_DATA_WIDTH        = 32,
  parameter int OPTN_ADDR_WIDTH        = 32,
  parameter int OPTN_DC_CACHE_SIZE     = 1024,
  parameter int OPTN_DC_LINE_SIZE      = 32,
  parameter int OPTN_DC_WAY_COUNT      = 1,
  parameter int OPTN_FILL_STARVE_LIMIT = 4,
  localparam int PCYN_LSU_FUNC_WIDTH   = 4,
  localparam int DC_LINE_WIDTH   = OPTN_DC_LINE_SIZE * 8,
  localparam int DC_OFFSET_WIDTH = $clog2(OPTN_DC_LINE_SIZE),
  localparam int DC_INDEX_WIDTH  =
    $clog2(OPTN_DC_CACHE_SIZE / OPTN_DC_LINE_SIZE / OPTN_DC_WAY_COUNT),
  localparam int DC_TAG_WIDTH    =
    OPTN_ADDR_WIDTH - DC_INDEX_WIDTH - DC_OFFSET_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_lsu_valid,
  input  logic                           i_lsu_we,
  input  logic [OPTN_ADDR_WIDTH-1:0]     i_lsu_addr,
  input  logic [PCYN_LSU_FUNC_WIDTH-1:0] i_lsu_func,
  input  logic [OPTN_DATA_WIDTH-1:0]     i_lsu_data,
  output logic                           o_lsu_stall,
  input  logic                           i_fill_valid,
  input  logic [OPTN_ADDR_WIDTH-1:0]     i_fill_addr,
  input  logic [DC_LINE_WIDTH-1:0]       i_fill_data,
  output logic                           o_fill_ack,
  output logic                           o_dc_req,
  output logic                           o_dc_wr_en,
  output logic [DC_TAG_WIDTH-1:0]        o_dc_tag,
  output logic [DC_INDEX_WIDTH-1:0]      o_dc_index,
  output logic [DC_OFFSET_WIDTH-1:0]     o_dc_offset,
  output logic [PCYN_LSU_FUNC_WIDTH-1:0] o_dc_lsu_func,
  output logic [OPTN_DATA_WIDTH-1:0]     o_dc_data,
  output logic                           o_dc_valid,
  output logic                           o_dc_dirty,
  output logic                           o_dc_fill,
  output logic [DC_LINE_WIDTH-1:0]       o_dc_fill_data
);

  localparam logic [PCYN_LSU_FUNC_WIDTH-1:0] PCYN_LSU_FUNC_LW = 4'd2;

  // Width kept >= 1 so LIMIT = 0 still yields a legal counter.
  localparam int STARVE_CNT_WIDTH =
    (OPTN_FILL_STARVE_LIMIT == 0) ? 1 : $clog2(OPTN_FILL_STARVE_LIMIT + 1);
  localparam logic [STARVE_CNT_WIDTH-1:0] STARVE_MAX =
    STARVE_CNT_WIDTH'(OPTN_FILL_STARVE_LIMIT);

  localparam int OFF_LO = 0;
  localparam int IDX_LO = DC_OFFSET_WIDTH;
  localparam int TAG_LO = DC_OFFSET_WIDTH + DC_INDEX_WIDTH;

  logic [STARVE_CNT_WIDTH-1:0]    starve_cnt_q, starve_cnt_d;
  logic                           fill_grant, lsu_grant;

  logic                           req_q, req_d;
  logic                           wr_en_q, wr_en_d;
  logic [DC_TAG_WIDTH-1:0]        tag_q, tag_d;
  logic [DC_INDEX_WIDTH-1:0]      index_q, index_d;
  logic [DC_OFFSET_WIDTH-1:0]     offset_q, offset_d;
  logic [PCYN_LSU_FUNC_WIDTH-1:0] func_q, func_d;
  logic [OPTN_DATA_WIDTH-1:0]     data_q, data_d;
  logic                           valid_q, valid_d;
  logic                           dirty_q, dirty_d;
  logic                           fill_q, fill_d;
  logic [DC_LINE_WIDTH-1:0]       fill_data_q, fill_data_d;

  // Grant: fills first unless the LSU has lost LIMIT times in a row.
  always_comb begin
    fill_grant = i_fill_valid
               & ~(i_lsu_valid & (starve_cnt_q == STARVE_MAX));
    lsu_grant  = i_lsu_valid & ~fill_grant;
    o_fill_ack  = ~rst & fill_grant;
    o_lsu_stall = ~rst & i_lsu_valid & ~lsu_grant;
  end

  // Count consecutive LSU losses, saturating at LIMIT.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (lsu_grant | ~i_lsu_valid) begin
      starve_cnt_d = '0;
    end else if (fill_grant & (starve_cnt_q != STARVE_MAX)) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  // Build the D0 op; address/data fields hold when idle.
  always_comb begin
    req_d       = 1'b0;
    wr_en_d     = 1'b0;
    valid_d     = 1'b0;
    dirty_d     = 1'b0;
    fill_d      = 1'b0;
    tag_d       = tag_q;
    index_d     = index_q;
    offset_d    = offset_q;
    func_d      = func_q;
    data_d      = data_q;
    fill_data_d = fill_data_q;
    unique case (1'b1)
      fill_grant: begin
        req_d       = 1'b1;
        wr_en_d     = 1'b1;
        tag_d       = i_fill_addr[TAG_LO +: DC_TAG_WIDTH];
        index_d     = i_fill_addr[IDX_LO +: DC_INDEX_WIDTH];
        offset_d    = i_fill_addr[OFF_LO +: DC_OFFSET_WIDTH]
                    & {DC_OFFSET_WIDTH{1'b0}};
        func_d      = PCYN_LSU_FUNC_LW;
        data_d      = '0;
        valid_d     = 1'b1;
        fill_d      = 1'b1;
        fill_data_d = i_fill_data;
      end
      lsu_grant: begin
        req_d       = 1'b1;
        wr_en_d     = i_lsu_we;
        tag_d       = i_lsu_addr[TAG_LO +: DC_TAG_WIDTH];
        index_d     = i_lsu_addr[IDX_LO +: DC_INDEX_WIDTH];
        offset_d    = i_lsu_addr[OFF_LO +: DC_OFFSET_WIDTH];
        func_d      = i_lsu_func;
        data_d      = i_lsu_data;
        valid_d     = 1'b1;
        dirty_d     = i_lsu_we;
        fill_data_d = '0;
      end
      default: ;
    endcase
  end

  // Register the D0 op and the starvation counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_q <= '0;
      req_q        <= 1'b0;
      wr_en_q      <= 1'b0;
      tag_q        <= '0;
      index_q      <= '0;
      offset_q     <= '0;
      func_q       <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      dirty_q      <= 1'b0;
      fill_q       <= 1'b0;
      fill_data_q  <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      req_q        <= req_d;
      wr_en_q      <= wr_en_d;
      tag_q        <= tag_d;
      index_q      <= index_d;
      offset_q     <= offset_d;
      func_q       <= func_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      dirty_q      <= dirty_d;
      fill_q       <= fill_d;
      fill_data_q  <= fill_data_d;
    end
  end

  assign o_dc_req       = req_q;
  assign o_dc_wr_en     = wr_en_q;
  assign o_dc_tag       = tag_q;
  assign o_dc_index     = index_q;
  assign o_dc_offset    = offset_q;
  assign o_dc_lsu_func  = func_q;
  assign o_dc_data      = data_q;
  assign o_dc_valid     = valid_q;
  assign o_dc_dirty     = dirty_q;
  assign o_dc_fill      = fill_q;
  assign o_dc_fill_data = fill_data_q;

endmodule

// File: tb/tb_procyon_dcache_arb.sv
// Directed bench for procyon_dcache_arb.
// Two instances: LIMIT = 4 and LIMIT = 0.
module tb_procyon_dcache_arb;

  logic         clk = 1'b0;
  logic         rst;
  logic         lsu_valid, lsu_we;
  logic [31:0]  lsu_addr, lsu_data;
  logic [3:0]   lsu_func;
  logic         fill_valid;
  logic [31:0]  fill_addr;
  logic [255:0] fill_data;

  logic         stall, ack, req, wr_en, valid, dirty, fill;
  logic [21:0]  tag;
  logic [4:0]   index, offset;
  logic [3:0]   func;
  logic [31:0]  data;
  logic [255:0] fdata;

  logic         stall0, ack0, req0, wr_en0, valid0, dirty0, fill0;
  logic [21:0]  tag0;
  logic [4:0]   index0, offset0;
  logic [3:0]   func0;
  logic [31:0]  data0;
  logic [255:0] fdata0;

  int checks = 0;
  int errors = 0;

  localparam logic [255:0] LINE = {8{32'hCAFE_F00D}} ^ 256'h1234_5678;

  always #5 clk = ~clk;

  procyon_dcache_arb #(.OPTN_FILL_STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .i_lsu_valid(lsu_valid), .i_lsu_we(lsu_we),
    .i_lsu_addr(lsu_addr), .i_lsu_func(lsu_func),
    .i_lsu_data(lsu_data), .o_lsu_stall(stall),
    .i_fill_valid(fill_valid), .i_fill_addr(fill_addr),
    .i_fill_data(fill_data), .o_fill_ack(ack),
    .o_dc_req(req), .o_dc_wr_en(wr_en), .o_dc_tag(tag),
    .o_dc_index(index), .o_dc_offset(offset),
    .o_dc_lsu_func(func), .o_dc_data(data),
    .o_dc_valid(valid), .o_dc_dirty(dirty),
    .o_dc_fill(fill), .o_dc_fill_data(fdata)
  );

  procyon_dcache_arb #(.OPTN_FILL_STARVE_LIMIT(0)) dut0 (
    .clk(clk), .rst(rst),
    .i_lsu_valid(lsu_valid), .i_lsu_we(lsu_we),
    .i_lsu_addr(lsu_addr), .i_lsu_func(lsu_func),
    .i_lsu_data(lsu_data), .o_lsu_stall(stall0),
    .i_fill_valid(fill_valid), .i_fill_addr(fill_addr),
    .i_fill_data(fill_data), .o_fill_ack(ack0),
    .o_dc_req(req0), .o_dc_wr_en(wr_en0), .o_dc_tag(tag0),
    .o_dc_index(index0), .o_dc_offset(offset0),
    .o_dc_lsu_func(func0), .o_dc_data(data0),
    .o_dc_valid(valid0), .o_dc_dirty(dirty0),
    .o_dc_fill(fill0), .o_dc_fill_data(fdata0)
  );

  task automatic idle();
    lsu_valid  = 1'b0;
    lsu_we     = 1'b0;
    fill_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle();
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    lsu_valid = 1'b1; lsu_we = 1'b1;
    lsu_addr = 32'h0000_1234; lsu_func = 4'd7;
    lsu_data = 32'h5555_AAAA;
    fill_valid = 1'b1; fill_addr = 32'h8000_0040;
    fill_data = LINE;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (ack !== 1'b0 || stall !== 1'b0) begin
        errors++;
        $display("FAIL reset_comb: ack=%b stall=%b want 0 0", ack, stall);
      end
      @(posedge clk); #1;
      checks++;
      if ({req, wr_en, tag, index, offset, func, data,
           valid, dirty, fill, fdata} !== '0) begin
        errors++;
        $display("FAIL reset_dc: req=%b tag=%h fill=%b want all 0",
                 req, tag, fill);
      end
      @(negedge clk);
    end
    rst = 1'b0;
    idle();
  endtask

  task automatic test_lone_load();
    @(negedge clk);
    lsu_valid = 1'b1; lsu_we = 1'b0;
    lsu_addr = 32'h0000_1234; lsu_func = 4'd2;
    lsu_data = 32'h0;
    #1;
    checks++;
    if (stall !== 1'b0 || ack !== 1'b0) begin
      errors++;
      $display("FAIL load_stall: stall=%b ack=%b want 0 0", stall, ack);
    end
    @(posedge clk); #1;
    checks++;
    if (req !== 1'b1 || wr_en !== 1'b0 || tag !== 22'h4 ||
        index !== 5'h11 || offset !== 5'h14 || func !== 4'd2) begin
      errors++;
      $display("FAIL load_dc: req=%b we=%b tag=%h idx=%h off=%h fn=%h want 1 0 4 11 14 2",
               req, wr_en, tag, index, offset, func);
    end
    checks++;
    if (valid !== 1'b1 || dirty !== 1'b0 || fill !== 1'b0) begin
      errors++;
      $display("FAIL load_bits: v=%b d=%b f=%b want 1 0 0",
               valid, dirty, fill);
    end
    @(negedge clk);
    idle();
    @(posedge clk); #1;
    checks++;
    if (req !== 1'b0 || valid !== 1'b0 || wr_en !== 1'b0 ||
        tag !== 22'h4 || index !== 5'h11 || offset !== 5'h14) begin
      errors++;
      $display("FAIL idle_hold: req=%b v=%b tag=%h idx=%h off=%h want 0 0 4 11 14",
               req, valid, tag, index, offset);
    end
  endtask

  task automatic test_lone_store();
    @(negedge clk);
    lsu_valid = 1'b1; lsu_we = 1'b1;
    lsu_addr = 32'h0000_0FFF; lsu_func = 4'd5;
    lsu_data = 32'h0000_00AB;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL store_stall: stall=%b want 0", stall);
    end
    @(posedge clk); #1;
    checks++;
    if (wr_en !== 1'b1 || dirty !== 1'b1 || fill !== 1'b0 ||
        data !== 32'hAB || func !== 4'd5) begin
      errors++;
      $display("FAIL store_dc: we=%b d=%b f=%b data=%h fn=%h want 1 1 0 ab 5",
               wr_en, dirty, fill, data, func);
    end
    checks++;
    if (tag !== 22'h3 || index !== 5'h1F || offset !== 5'h1F) begin
      errors++;
      $display("FAIL store_addr: tag=%h idx=%h off=%h want 3 1f 1f",
               tag, index, offset);
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_fill();
    @(negedge clk);
    fill_valid = 1'b1; fill_addr = 32'h8000_0047;
    fill_data = LINE;
    #1;
    checks++;
    if (ack !== 1'b1 || stall !== 1'b0) begin
      errors++;
      $display("FAIL fill_ack: ack=%b stall=%b want 1 0", ack, stall);
    end
    @(posedge clk); #1;
    checks++;
    if (req !== 1'b1 || wr_en !== 1'b1 || fill !== 1'b1 ||
        offset !== 5'h0 || valid !== 1'b1 || dirty !== 1'b0) begin
      errors++;
      $display("FAIL fill_dc: req=%b we=%b f=%b off=%h v=%b d=%b want 1 1 1 0 1 0",
               req, wr_en, fill, offset, valid, dirty);
    end
    checks++;
    if (tag !== 22'h20_0000 || index !== 5'h2 || fdata !== LINE ||
        func !== 4'd2 || data !== 32'h0) begin
      errors++;
      $display("FAIL fill_payload: tag=%h idx=%h fn=%h data=%h want 200000 2 2 0",
               tag, index, func, data);
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_starvation();
    logic exp_ack;
    do_reset();
    lsu_valid = 1'b1; lsu_we = 1'b0;
    lsu_addr = 32'h0000_1234; lsu_func = 4'd2;
    lsu_data = 32'h0;
    fill_valid = 1'b1; fill_addr = 32'h8000_0040;
    fill_data = LINE;
    for (int k = 0; k < 9; k++) begin
      exp_ack = (k != 4);
      #1;
      checks++;
      if (ack !== exp_ack || stall !== exp_ack) begin
        errors++;
        $display("FAIL starve_grant[%0d]: ack=%b stall=%b want %b %b",
                 k, ack, stall, exp_ack, exp_ack);
      end
      checks++;
      if (ack0 !== 1'b0 || stall0 !== 1'b0) begin
        errors++;
        $display("FAIL limit0_grant[%0d]: ack=%b stall=%b want 0 0",
                 k, ack0, stall0);
      end
      @(posedge clk); #1;
      checks++;
      if (req !== 1'b1 || fill !== exp_ack || dirty !== 1'b0) begin
        errors++;
        $display("FAIL starve_dc[%0d]: req=%b fill=%b want 1 %b",
                 k, req, fill, exp_ack);
      end
      checks++;
      if (req0 !== 1'b1 || fill0 !== 1'b0 || tag0 !== 22'h4) begin
        errors++;
        $display("FAIL limit0_dc[%0d]: req=%b fill=%b tag=%h want 1 0 4",
                 k, req0, fill0, tag0);
      end
      @(negedge clk);
    end
    lsu_valid = 1'b0;
    #1;
    checks++;
    if (ack0 !== 1'b1 || ack !== 1'b1) begin
      errors++;
      $display("FAIL limit0_idle: ack0=%b ack=%b want 1 1", ack0, ack);
    end
    @(posedge clk); #1;
    checks++;
    if (fill0 !== 1'b1 || fdata0 !== LINE || index0 !== 5'h2) begin
      errors++;
      $display("FAIL limit0_fill: fill=%b idx=%h want 1 2", fill0, index0);
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    lsu_valid = 1'b1; lsu_we = 1'b0;
    fill_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (ack !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst_comb: ack=%b stall=%b want 0 0", ack, stall);
    end
    @(posedge clk); #1;
    checks++;
    if (req !== 1'b0 || fill !== 1'b0 || tag !== '0 || fdata !== '0) begin
      errors++;
      $display("FAIL mid_rst_dc: req=%b fill=%b tag=%h want 0 0 0",
               req, fill, tag);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      exp_chk: begin
        #1;
        checks++;
        if (ack !== (k != 4)) begin
          errors++;
          $display("FAIL mid_rst_cnt[%0d]: ack=%b want %b",
                   k, ack, (k != 4));
        end
      end
      @(posedge clk); #1;
      @(negedge clk);
    end
    idle();
  endtask

  task automatic test_back_to_back();
    do_reset();
    lsu_valid = 1'b1; lsu_we = 1'b1;
    lsu_addr = 32'h0000_0400; lsu_func = 4'd7;
    lsu_data = 32'h1111_1111;
    @(posedge clk); #1;
    checks++;
    if (req !== 1'b1 || tag !== 22'h1 || data !== 32'h1111_1111) begin
      errors++;
      $display("FAIL b2b_0: req=%b tag=%h data=%h want 1 1 11111111",
               req, tag, data);
    end
    @(negedge clk);
    lsu_we = 1'b0; lsu_addr = 32'h0000_0820; lsu_func = 4'd0;
    @(posedge clk); #1;
    checks++;
    if (req !== 1'b1 || wr_en !== 1'b0 || tag !== 22'h2 ||
        index !== 5'h1 || func !== 4'd0) begin
      errors++;
      $display("FAIL b2b_1: req=%b we=%b tag=%h idx=%h fn=%h want 1 0 2 1 0",
               req, wr_en, tag, index, func);
    end
    @(negedge clk);
    idle();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    lsu_addr = '0; lsu_func = '0; lsu_data = '0;
    fill_addr = '0; fill_data = '0;
    test_reset();
    test_lone_load();
    test_lone_store();
    test_fill();
    test_starvation();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
